// File: rtl/pipe_stage_buffer.sv
// In-order DEPTH-entry inter-stage buffer (ctrl + data) with valid/ready, flush and bubble zeroing.
// Latency 1 cycle; in_ready depends only on registered occupancy, so a stall backs up without a comb path.
module pipe_stage_buffer #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int DEPTH  = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CW-1:0]     count
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        in_ready  = (count_q < CW'(DEPTH));
        out_valid = (count_q != '0);
        push      = in_valid & in_ready & ~flush;
        pop       = out_valid & out_ready & ~flush;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = ptr_inc(wptr_q);
            if (pop)  rptr_d = ptr_inc(rptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wptr_q] <= '{ctrl: in_ctrl, data: in_data};
        end
    end

    // An empty buffer presents a bubble: all-zero control means no downstream side effects.
    assign out_ctrl = out_valid ? mem_q[rptr_q].ctrl : '0;
    assign out_data = out_valid ? mem_q[rptr_q].data : '0;
    assign count    = count_q;

endmodule
